// File: rtl/rotate_req_pipe.sv
// Back-pressurable rotate unit: a request FIFO feeds an external combinational
// circular shifter, and the shifter result is captured into a registered output stage.
module rotate_req_pipe #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data,
    input  logic [4:0]       req_amt,
    input  logic             req_dir,
    output logic [31:0]      rot_in_data,
    output logic [4:0]       rot_shift_amt,
    output logic             rot_dir,
    input  logic [31:0]      rot_out_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [CNT_W-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 38;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             full, nonempty, push, load;
    logic [ENT_W-1:0] head;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        nonempty = (count_q != '0);
        // Gating with rst_n keeps the input closed for the whole reset window.
        req_ready = rst_n && !full;
        push     = req_valid && req_ready;
        load     = nonempty && (!rsp_valid_q || rsp_ready);
        head     = nonempty ? mem_q[rd_ptr_q] : '0;
    end

    assign rot_dir       = head[37];
    assign rot_shift_amt = head[36:32];
    assign rot_in_data   = head[31:0];

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case ({push, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (load) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rot_out_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage is plain data; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_dir, req_amt, req_data};
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign occupancy = count_q + CNT_W'(rsp_valid_q);
endmodule

// File: tb/tb_rotate_req_pipe.sv
// Directed bench for rotate_req_pipe; the bench also plays the external shifter.
module tb_rotate_req_pipe;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 2);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_data;
    logic [4:0]       req_amt;
    logic             req_dir;
    logic [31:0]      rot_in_data;
    logic [4:0]       rot_shift_amt;
    logic             rot_dir;
    logic [31:0]      rot_out_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [CNT_W-1:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    rotate_req_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_amt       (req_amt),
        .req_dir       (req_dir),
        .rot_in_data   (rot_in_data),
        .rot_shift_amt (rot_shift_amt),
        .rot_dir       (rot_dir),
        .rot_out_data  (rot_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shifter(input logic [31:0] x, input logic [4:0] a, input logic l);
        logic [63:0] t;
        t = {x, x};
        if (l) begin
            t = t << a;
            return t[63:32];
        end
        t = t >> a;
        return t[31:0];
    endfunction

    assign rot_out_data = shifter(rot_in_data, rot_shift_amt, rot_dir);

    // Reference rotate, one bit position at a time.
    function automatic logic [31:0] ref_rot(input logic [31:0] x, input logic [4:0] a, input logic l);
        logic [31:0] r;
        r = x;
        for (int k = 0; k < int'(a); k++) begin
            r = l ? {r[30:0], r[31]} : {r[0], r[31:1]};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] d, input logic [4:0] a, input logic l);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_dir   = l;
    endtask

    task automatic do_single(input string tag, input logic [31:0] d, input logic [4:0] a,
                             input logic l, input logic [31:0] exp);
        rsp_ready = 1'b1;
        drive_req(d, a, l);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_lat"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_data, exp);
        tick();
        chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int accepted;
        int sent;
        int got;
        logic [31:0] exp_q[$];
        logic prev_stall;
        logic [31:0] prev_data;
        logic acc;

        rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_amt = '0; req_dir = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data", rsp_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);
        chk("empty_rot", rot_in_data, 32'h0);

        do_single("left1", 32'h8000_0001, 5'd1, 1'b1, 32'h0000_0003);
        do_single("right4", 32'h1234_5678, 5'd4, 1'b0, 32'h8123_4567);

        // Back-to-back amount 0 then amount 31.
        rsp_ready = 1'b1;
        drive_req(32'hDEAD_BEEF, 5'd0, 1'b1);
        tick();
        drive_req(32'h0000_0001, 5'd31, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("b2b0_valid", 32'(rsp_valid), 32'd1);
        chk("b2b0_data", rsp_data, 32'hDEAD_BEEF);
        tick();
        chk("b2b1_valid", 32'(rsp_valid), 32'd1);
        chk("b2b1_data", rsp_data, 32'h8000_0000);
        tick();
        chk("b2b_drop", 32'(rsp_valid), 32'd0);

        // Backpressure: only DEPTH+1 requests fit.
        rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 1; i <= 6; i++) begin
            drive_req(32'(i), 5'd0, 1'b0);
            if (req_ready) accepted++;
            tick();
        end
        chk("bp_accepted", 32'(accepted), 32'd5);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_occ", 32'(occupancy), 32'd5);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp_d1", rsp_data, 32'h1);
        chk("bp_ready_popcyc", 32'(req_ready), 32'd0);
        tick();
        chk("bp_ready_after", 32'(req_ready), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("bp_v%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_d%0d", i), rsp_data, 32'(i));
            tick();
        end
        chk("bp_drain_valid", 32'(rsp_valid), 32'd0);
        chk("bp_drain_occ", 32'(occupancy), 32'd0);

        // Random streaming against the reference model.
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
            if (!req_valid && sent < 64 && $urandom_range(0, 3) != 0)
                drive_req($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (prev_stall) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_data", rsp_data, prev_data);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("stream_extra", 32'(got + 1), 32'(got));
                else chk($sformatf("stream_%0d", got), rsp_data, exp_q.pop_front());
                got++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            acc = req_valid && req_ready;
            if (acc) begin
                exp_q.push_back(ref_rot(req_data, req_amt, req_dir));
                sent++;
            end
            tick();
            if (acc) req_valid = 1'b0;
        end
        chk("stream_count", 32'(got), 32'd64);

        // Reset mid-operation discards everything in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(32'hA000_0000 + 32'(i), 5'd3, 1'b1);
            tick();
        end
        req_valid = 1'b0;
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_stale%0d", i), 32'(rsp_valid), 32'd0);
        end
        do_single("post_rst", 32'h0000_00F0, 5'd8, 1'b0, 32'hF000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
